// File: rtl/rgb2gray_pkg.sv
// Shared definitions for the RGB-to-gray pixel sender: FSM states and byte-lane positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rgb2gray_pkg;

  localparam int PIX_W = 24;

  // Top bit of each colour byte inside a packed {R,G,B} pixel.
  localparam int R_HI = 23;
  localparam int G_HI = 15;
  localparam int B_HI = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_R = 3'd1,
    ST_SEND_G = 3'd2,
    ST_SEND_B = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Generic synchronous FIFO holding packed pixels between the upstream port and the sender FSM.
// Latency: one cycle from push edge to visible head; head is read combinationally.
// Backpressure: full_o refuses pushes even when a pop happens in the same cycle.
// Ports: clk_i/rst_i clock and async active-low reset; push_i/push_dat_i write side;
//        pop_i read side; head_dat_o oldest entry; full_o/empty_o occupancy flags.
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (cnt_q == FULL_CNT);
  assign empty_o    = (cnt_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH (power of two).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/rgb_pixel_sender.sv
// Queues 24-bit pixels and streams R, G, B bytes to a gray converter, then collects its result.
// Latency: start_o two cycles after a pixel is accepted into an idle, empty block; gray one cycle after conv_valid_i.
// Backpressure: pix_ready_o drops when the pixel FIFO is full; a silent converter is abandoned after TIMEOUT_CYC WAIT cycles.
// Ports: pix_* upstream pixel handshake; start_o/RgbColor_o byte stream to converter;
//        conv_* converter result; gray_*, busy_o, timeout_o, pix_count_o results and status.
module rgb_pixel_sender
  import rgb2gray_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pix_valid_i,
  input  logic [PIX_W-1:0] pix_data_i,
  output logic             pix_ready_o,
  output logic             start_o,
  output logic [7:0]       RgbColor_o,
  input  logic             conv_valid_i,
  input  logic [7:0]       conv_gray_i,
  output logic             gray_valid_o,
  output logic [7:0]       gray_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [15:0]      pix_count_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e           state_q;
  logic [PIX_W-1:0] hold_q;
  logic [7:0]       cnt_q;
  logic             start_q;
  logic [7:0]       color_q;
  logic [7:0]       gray_q;
  logic             gray_vld_q;
  logic             timeout_q;
  logic [15:0]      pix_cnt_q;
  logic             rdy_en_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [PIX_W-1:0] fifo_head;

  // rdy_en_q keeps pix_ready_o low during reset, where the empty FIFO would otherwise report not-full.
  assign pix_ready_o = rdy_en_q & ~fifo_full;
  assign fifo_pop    = (state_q == ST_IDLE) & ~fifo_empty;

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (pix_valid_i & pix_ready_o),
    .push_dat_i (pix_data_i),
    .pop_i      (fifo_pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Byte outputs are loaded on the transition into each SEND state so they line up with the state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      color_q    <= '0;
      gray_q     <= '0;
      gray_vld_q <= 1'b0;
      timeout_q  <= 1'b0;
      pix_cnt_q  <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      gray_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            hold_q  <= fifo_head;
            start_q <= 1'b1;
            color_q <= fifo_head[R_HI -: 8];
            state_q <= ST_SEND_R;
          end
        end
        ST_SEND_R: begin
          start_q <= 1'b0;
          color_q <= hold_q[G_HI -: 8];
          state_q <= ST_SEND_G;
        end
        ST_SEND_G: begin
          color_q <= hold_q[B_HI -: 8];
          state_q <= ST_SEND_B;
        end
        ST_SEND_B: begin
          color_q <= '0;
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the last allowed cycle still counts.
          if (conv_valid_i) begin
            gray_q     <= conv_gray_i;
            gray_vld_q <= 1'b1;
            pix_cnt_q  <= pix_cnt_q + 16'd1;
            state_q    <= ST_IDLE;
          end else if (cnt_q == TMO_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          start_q <= 1'b0;
          color_q <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_o      = start_q;
  assign RgbColor_o   = color_q;
  assign gray_valid_o = gray_vld_q;
  assign gray_o       = gray_q;
  assign timeout_o    = timeout_q;
  assign pix_count_o  = pix_cnt_q;
  assign busy_o       = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_rgb_pixel_sender.sv
module tb_rgb_pixel_sender;

  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic [23:0] pix_data_i = '0;
  logic        pix_ready_o;
  logic        start_o;
  logic [7:0]  RgbColor_o;
  logic        conv_valid_i = 1'b0;
  logic [7:0]  conv_gray_i = '0;
  logic        gray_valid_o;
  logic [7:0]  gray_o;
  logic        busy_o;
  logic        timeout_o;
  logic [15:0] pix_count_o;

  int checks = 0;
  int errors = 0;

  rgb_pixel_sender #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pix_valid_i  (pix_valid_i),
    .pix_data_i   (pix_data_i),
    .pix_ready_o  (pix_ready_o),
    .start_o      (start_o),
    .RgbColor_o   (RgbColor_o),
    .conv_valid_i (conv_valid_i),
    .conv_gray_i  (conv_gray_i),
    .gray_valid_o (gray_valid_o),
    .gray_o       (gray_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .pix_count_o  (pix_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Advance one clock; outputs are then sampled at the falling edge.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    pix_valid_i = 1'b0;
    conv_valid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({pix_ready_o, start_o, RgbColor_o, gray_valid_o, gray_o, busy_o, timeout_o, pix_count_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b st=%b col=%h gv=%b g=%h busy=%b to=%b cnt=%h, required all 0",
               pix_ready_o, start_o, RgbColor_o, gray_valid_o, gray_o, busy_o, timeout_o, pix_count_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    checks++;
    if (pix_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b busy=%b, required rdy=1 busy=0", pix_ready_o, busy_o);
    end
  endtask

  task automatic test_single();
    apply_reset();
    pix_data_i = 24'h123456;
    pix_valid_i = 1'b1;
    tick();
    pix_valid_i = 1'b0;
    checks++;
    if (start_o !== 1'b0) begin
      errors++;
      $display("FAIL single_start_early: got start=%b, required 0", start_o);
    end
    tick();
    checks++;
    if (start_o !== 1'b1 || RgbColor_o !== 8'h12) begin
      errors++;
      $display("FAIL single_R: got start=%b col=%h, required start=1 col=12", start_o, RgbColor_o);
    end
    tick();
    checks++;
    if (start_o !== 1'b0 || RgbColor_o !== 8'h34) begin
      errors++;
      $display("FAIL single_G: got start=%b col=%h, required start=0 col=34", start_o, RgbColor_o);
    end
    tick();
    checks++;
    if (start_o !== 1'b0 || RgbColor_o !== 8'h56) begin
      errors++;
      $display("FAIL single_B: got start=%b col=%h, required start=0 col=56", start_o, RgbColor_o);
    end
    tick();
    checks++;
    if (start_o !== 1'b0 || RgbColor_o !== 8'h00 || gray_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_wait_idle: got start=%b col=%h gv=%b, required 0 00 0", start_o, RgbColor_o, gray_valid_o);
    end
    tick();
    tick();
    conv_valid_i = 1'b1;
    conv_gray_i = 8'h40;
    tick();
    conv_valid_i = 1'b0;
    checks++;
    if (gray_valid_o !== 1'b1 || gray_o !== 8'h40 || pix_count_o !== 16'd1) begin
      errors++;
      $display("FAIL single_result: got gv=%b gray=%h cnt=%0d, required gv=1 gray=40 cnt=1", gray_valid_o, gray_o, pix_count_o);
    end
    tick();
    checks++;
    if (gray_valid_o !== 1'b0 || gray_o !== 8'h40 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got gv=%b gray=%h busy=%b, required gv=0 gray=40 busy=0", gray_valid_o, gray_o, busy_o);
    end
  endtask

  task automatic test_backpressure();
    int accepted;
    apply_reset();
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      pix_valid_i = 1'b1;
      pix_data_i = 24'($urandom);
      checks++;
      if (pix_ready_o !== (i < 5)) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b, required %b", i, pix_ready_o, (i < 5));
      end
      if (pix_ready_o === 1'b1) accepted++;
      tick();
    end
    pix_valid_i = 1'b0;
    checks++;
    if (accepted != 5 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_accepted: got accepted=%0d busy=%b, required 5 and 1", accepted, busy_o);
    end
  endtask

  task automatic test_timeout();
    int bad;
    apply_reset();
    pix_data_i = 24'hAABBCC;
    pix_valid_i = 1'b1;
    tick();
    pix_data_i = 24'h010203;
    tick();
    pix_valid_i = 1'b0;
    checks++;
    if (start_o !== 1'b1 || RgbColor_o !== 8'hAA) begin
      errors++;
      $display("FAIL tmo_R: got start=%b col=%h, required 1 AA", start_o, RgbColor_o);
    end
    tick();
    tick();
    bad = 0;
    for (int k = 0; k < TMO; k++) begin
      tick();
      if (gray_valid_o !== 1'b0 || timeout_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tmo_early: got %0d cycles with gv/timeout set during WAIT, required 0", bad);
    end
    tick();
    checks++;
    if (timeout_o !== 1'b1 || gray_valid_o !== 1'b0 || pix_count_o !== 16'd0) begin
      errors++;
      $display("FAIL tmo_flag: got to=%b gv=%b cnt=%0d, required to=1 gv=0 cnt=0", timeout_o, gray_valid_o, pix_count_o);
    end
    tick();
    checks++;
    if (start_o !== 1'b1 || RgbColor_o !== 8'h01) begin
      errors++;
      $display("FAIL tmo_next_R: got start=%b col=%h, required 1 01", start_o, RgbColor_o);
    end
    tick();
    tick();
    checks++;
    if (RgbColor_o !== 8'h03) begin
      errors++;
      $display("FAIL tmo_next_B: got col=%h, required 03", RgbColor_o);
    end
    // Answer on the very last WAIT cycle: the result must beat the timeout.
    for (int k = 1; k <= TMO; k++) tick();
    conv_valid_i = 1'b1;
    conv_gray_i = 8'h5A;
    tick();
    conv_valid_i = 1'b0;
    checks++;
    if (gray_valid_o !== 1'b1 || gray_o !== 8'h5A || pix_count_o !== 16'd1 || timeout_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_last_cycle: got gv=%b gray=%h cnt=%0d to=%b, required 1 5A 1 1",
               gray_valid_o, gray_o, pix_count_o, timeout_o);
    end
  endtask

  task automatic test_reset_midpixel();
    int bad;
    logic [23:0] pix [3];
    pix[0] = 24'h0A0B0C;
    pix[1] = 24'h1A1B1C;
    pix[2] = 24'h2A2B2C;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      pix_valid_i = 1'b1;
      pix_data_i = pix[i];
      tick();
    end
    pix_valid_i = 1'b0;
    checks++;
    if (start_o !== 1'b0 || RgbColor_o !== 8'h0B) begin
      errors++;
      $display("FAIL mid_sendG: got start=%b col=%h, required 0 0B", start_o, RgbColor_o);
    end
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (start_o !== 1'b0 || RgbColor_o !== 8'h00 || pix_ready_o !== 1'b0 || busy_o !== 1'b0 || gray_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got start=%b col=%h rdy=%b busy=%b gv=%b, required all 0",
               start_o, RgbColor_o, pix_ready_o, busy_o, gray_valid_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || pix_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: got busy=%b rdy=%b, required 0 1", busy_o, pix_ready_o);
    end
    conv_valid_i = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (start_o !== 1'b0 || gray_valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
    end
    conv_valid_i = 1'b0;
    checks++;
    if (bad != 0 || pix_count_o !== 16'd0) begin
      errors++;
      $display("FAIL mid_flushed: got %0d active cycles cnt=%0d, required 0 and 0", bad, pix_count_o);
    end
  endtask

  task automatic test_conv_ignored();
    int bad;
    apply_reset();
    bad = 0;
    conv_valid_i = 1'b1;
    conv_gray_i = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (gray_valid_o !== 1'b0) bad++;
    end
    conv_valid_i = 1'b0;
    pix_data_i = 24'h778899;
    pix_valid_i = 1'b1;
    tick();
    pix_valid_i = 1'b0;
    tick();
    checks++;
    if (start_o !== 1'b1 || RgbColor_o !== 8'h77) begin
      errors++;
      $display("FAIL ign_R: got start=%b col=%h, required 1 77", start_o, RgbColor_o);
    end
    conv_valid_i = 1'b1;
    tick();
    conv_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (gray_valid_o !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || pix_count_o !== 16'd0) begin
      errors++;
      $display("FAIL ign_conv: got %0d strobes cnt=%0d, required 0 and 0", bad, pix_count_o);
    end
  endtask

  // Scoreboard: accepted pixels queue, each must appear as R/G/B bytes in order;
  // the converter answers after a random delay (or never) and the result/count/flag follow.
  task automatic test_random();
    logic [23:0] exp_q [$];
    logic [23:0] cur;
    logic [15:0] exp_cnt;
    logic [7:0]  gexp;
    logic        gv_exp;
    logic        tmo_next;
    logic        exp_tmo;
    logic        exp_busy;
    int          ph;
    int          wk;
    int          dly;
    int          r;
    apply_reset();
    cur = '0; exp_cnt = '0; gexp = '0; gv_exp = 1'b0; tmo_next = 1'b0; exp_tmo = 1'b0;
    ph = 0; wk = 0; dly = 0;
    for (int c = 0; c < 1500; c++) begin
      if (gv_exp) exp_cnt = exp_cnt + 16'd1;
      if (tmo_next) exp_tmo = 1'b1;
      checks++;
      if (gray_valid_o !== gv_exp || (gv_exp && gray_o !== gexp)) begin
        errors++;
        $display("FAIL rnd_gray[%0d]: got gv=%b gray=%h, required gv=%b gray=%h", c, gray_valid_o, gray_o, gv_exp, gexp);
      end
      checks++;
      if (pix_count_o !== exp_cnt || timeout_o !== exp_tmo) begin
        errors++;
        $display("FAIL rnd_status[%0d]: got cnt=%0d to=%b, required cnt=%0d to=%b", c, pix_count_o, timeout_o, exp_cnt, exp_tmo);
      end
      exp_busy = (ph != 0) || (exp_q.size() != 0);
      checks++;
      if (busy_o !== exp_busy) begin
        errors++;
        $display("FAIL rnd_busy[%0d]: got %b, required %b", c, busy_o, exp_busy);
      end
      gv_exp = 1'b0;
      tmo_next = 1'b0;
      conv_valid_i = ($urandom_range(0, 3) == 0);
      conv_gray_i = 8'($urandom);
      checks++;
      case (ph)
        0: begin
          if (start_o === 1'b1) begin
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rnd_start[%0d]: got start=1 with nothing queued, required 0", c);
            end else begin
              cur = exp_q.pop_front();
              if (RgbColor_o !== cur[23:16]) begin
                errors++;
                $display("FAIL rnd_R[%0d]: got %h, required %h", c, RgbColor_o, cur[23:16]);
              end
            end
            ph = 1;
          end else if (RgbColor_o !== 8'h00) begin
            errors++;
            $display("FAIL rnd_idle_col[%0d]: got %h, required 00", c, RgbColor_o);
          end
        end
        1: begin
          if (start_o !== 1'b0 || RgbColor_o !== cur[15:8]) begin
            errors++;
            $display("FAIL rnd_G[%0d]: got start=%b col=%h, required 0 %h", c, start_o, RgbColor_o, cur[15:8]);
          end
          ph = 2;
        end
        2: begin
          if (start_o !== 1'b0 || RgbColor_o !== cur[7:0]) begin
            errors++;
            $display("FAIL rnd_B[%0d]: got start=%b col=%h, required 0 %h", c, start_o, RgbColor_o, cur[7:0]);
          end
          ph = 3;
          wk = 0;
          r = $urandom_range(0, 9);
          if (r == 0)      dly = 1000;
          else if (r == 1) dly = TMO - 1;
          else             dly = $urandom_range(0, 6);
        end
        default: begin
          if (start_o !== 1'b0 || RgbColor_o !== 8'h00) begin
            errors++;
            $display("FAIL rnd_wait[%0d]: got start=%b col=%h, required 0 00", c, start_o, RgbColor_o);
          end
          conv_valid_i = 1'b0;
          if (wk == dly) begin
            conv_valid_i = 1'b1;
            gexp = conv_gray_i;
            gv_exp = 1'b1;
            ph = 0;
          end else if (wk == TMO - 1) begin
            tmo_next = 1'b1;
            ph = 0;
          end
          wk++;
        end
      endcase
      pix_valid_i = $urandom_range(0, 1) == 1;
      pix_data_i = 24'($urandom);
      if (pix_valid_i && pix_ready_o === 1'b1) exp_q.push_back(pix_data_i);
      tick();
    end
    pix_valid_i = 1'b0;
    conv_valid_i = 1'b0;
  endtask

  task automatic test_wrap();
    int strobes;
    bit done;
    apply_reset();
    strobes = 0;
    done = 1'b0;
    pix_valid_i = 1'b1;
    pix_data_i = 24'hC0FFEE;
    conv_valid_i = 1'b1;
    conv_gray_i = 8'h3C;
    for (int c = 0; c < 400000 && !done; c++) begin
      tick();
      if (gray_valid_o === 1'b1) begin
        strobes++;
        if (strobes == 1 || strobes == 65535) begin
          checks++;
          if (pix_count_o !== 16'(strobes)) begin
            errors++;
            $display("FAIL wrap_count[%0d]: got %h, required %h", strobes, pix_count_o, 16'(strobes));
          end
        end
        if (strobes == 65536) begin
          checks++;
          if (pix_count_o !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h, required 0000", pix_count_o);
          end
          done = 1'b1;
        end
      end
    end
    pix_valid_i = 1'b0;
    conv_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wrap_budget: got %0d strobes in cycle budget, required 65536", strobes);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_timeout();
    test_reset_midpixel();
    test_conv_ignored();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pixel_sender.md
RGB_PIXEL_SENDER -- requirements
Module: rgb_pixel_sender

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 64, max WAIT cycles per pixel (2..255).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  rising-edge clock; rst_i  in  1  asynchronous active-low reset.
REQ-004 The pixel input ports SHALL be: pix_valid_i  in  1  upstream pixel valid; pix_data_i  in  24  {R[23:16],G[15:8],B[7:0]}; pix_ready_o  out  1  FIFO can accept.
REQ-005 The converter-side ports SHALL be: start_o  out  1  byte-stream start strobe; RgbColor_o  out  8  R/G/B byte; conv_valid_i  in  1  converter result valid; conv_gray_i  in  8  converter gray result.
REQ-006 The result and status ports SHALL be: gray_valid_o  out  1  gray result strobe; gray_o  out  8  gray value; busy_o  out  1  work pending; timeout_o  out  1  sticky timeout flag; pix_count_o  out  16  completed-pixel count.

Function
REQ-007 A pixel SHALL be pushed on a rising edge with pix_valid_i=1 and pix_ready_o=1; pix_ready_o = FIFO not full, with no same-cycle bypass (full FIFO refuses a push even if a pop occurs that cycle).
REQ-008 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-009 The FSM SHALL have states IDLE, SEND_R, SEND_G, SEND_B, WAIT.
REQ-010 IDLE: if FIFO non-empty, pop head into a 24-bit hold register and go to SEND_R; otherwise stay.
REQ-011 SEND_R SHALL drive start_o=1 and RgbColor_o=R; SEND_G SHALL drive RgbColor_o=G; SEND_B SHALL drive RgbColor_o=B; each lasts exactly one cycle, then SEND_G, SEND_B, WAIT in order.
REQ-012 In IDLE and WAIT, start_o SHALL be 0 and RgbColor_o SHALL be 0x00.
REQ-013 start_o SHALL first assert on the second cycle after a pixel's acceptance edge when the FSM was idle with an empty FIFO.
REQ-014 WAIT: a cycle counter SHALL start at 0; when conv_valid_i=1 is sampled, the block SHALL register conv_gray_i into gray_o, pulse gray_valid_o for exactly the next cycle, increment pix_count_o (65535 wraps to 0), and return to IDLE.
REQ-015 If the counter reaches TIMEOUT_CYC-1 without conv_valid_i, the block SHALL set timeout_o=1, drop the pixel, produce no gray_valid_o, leave pix_count_o unchanged, and return to IDLE.
REQ-016 If conv_valid_i and the timeout occur in the same cycle, conv_valid_i SHALL win.
REQ-017 conv_valid_i SHALL be ignored in IDLE, SEND_R, SEND_G and SEND_B.
REQ-018 gray_o SHALL hold its last value between strobes.
REQ-019 busy_o SHALL be 1 whenever the state is not IDLE or the FIFO is non-empty.
REQ-020 timeout_o SHALL be sticky and clear only on reset.

Reset
REQ-021 While rst_i=0 the block SHALL immediately (asynchronously) force state IDLE, an empty FIFO, a zero hold register and counter, and all outputs 0, including pix_ready_o, gray_o and pix_count_o.
REQ-022 A reset asserted mid-pixel SHALL abandon that pixel and all FIFO contents, with no gray_valid_o on exit.
REQ-023 pix_ready_o SHALL rise in the first cycle after rst_i deasserts.

Structure
REQ-024 The FSM state encoding and the byte-lane index constants (R_HI=23, G_HI=15, B_HI=7) SHALL live in the shared package rgb2gray_pkg.
REQ-025 The FIFO SHALL be a separate sub-module, pixel_fifo (parameters WIDTH=24, DEPTH); the FSM, counter and output registers SHALL stay in rgb_pixel_sender.

Verification
REQ-026 The bench SHALL cover single pixel 0x123456 with the converter model asserting conv_valid_i and conv_gray_i=0x40 three cycles after SEND_B -> one start_o cycle with RgbColor_o=0x12, then 0x34, then 0x56; then gray_o=0x40 with a one-cycle gray_valid_o; pix_count_o=1.
REQ-027 The bench SHALL cover a silent converter with 6 pixels offered back-to-back -> 5 accepted (1 held plus 4 in FIFO), pix_ready_o=0 on the sixth, and busy_o=1.
REQ-028 The bench SHALL cover no conv_valid_i for pixel 0xAABBCC -> timeout_o=1 after 64 WAIT cycles, no gray_valid_o, pix_count_o unchanged; the next queued pixel then starts normally.
REQ-029 The bench SHALL cover rst_i low during SEND_G -> start_o=0, RgbColor_o=0x00 and pix_ready_o=0 immediately; after release FIFO empty, busy_o=0, and queued pixels are never sent.
REQ-030 The bench SHALL cover conv_valid_i pulsed in IDLE and SEND_R -> no gray_valid_o and pix_count_o unchanged.
REQ-031 The bench SHALL cover 65536 completed pixels -> pix_count_o wraps to 0x0000.
